dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the single-port word-addressed data memory.
- Port 0 is the pipeline MEM stage. Port 1 is a secondary master, such as a test loader or DMA.
- Serialises accesses, holds the memory address, data and strobes stable for a programmable number of cycles, captures read data, and returns a one-cycle ack per access.

---
 rtl/dmem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of the single-port,
//   word-addressed data memory. Port 0 is the pipeline MEM stage, port 1 a
//   secondary master (loader / DMA). One access at a time is latched, the
//   memory address/data/strobes are held for ACCESS_CYCLES cycles, read data is
//   captured, and a one-cycle ack is returned to the granted port.
//
// Parameters
//   ACCESS_CYCLES  cycles the memory strobes are held per access (1..15)
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   req0/we0/addr0/wdata0      port 0 request, type (1=write), address, data
//   ack0/rdata0                port 0 one-cycle completion, read data
//   req1/we1/addr1/wdata1      port 1 request fields
//   ack1/rdata1                port 1 completion, read data
//   mem_address/mem_writeData  address and write data to the data memory
//   mem_memRead/mem_memWrite   read and write strobes to the data memory
//   mem_out                    combinational read data from the data memory
//   busy                       FSM not in IDLE
//   err                        misaligned-access flag (pulses with ack)
//
// Optional feature
//   DMEM_ARB_ALIGN_CHECK_EN    when defined, a granted access whose address has
//                              addr[1:0]!=0 skips the memory, acks with err=1
//                              and returns rdata=0. When undefined err is 0 and
//                              addr[1:0] is passed through untouched.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_out,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gid;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Winner selection: a lone requester wins; on a tie the port that did not
  // win last time gets the grant, which yields strict alternation under load.
  logic        any_req;
  logic        winner;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_we;
  logic        win_mis;

  assign any_req   = req0 | req1;
  assign winner    = (req0 & req1) ? ~last_grant : req1;
  assign win_addr  = winner ? addr1  : addr0;
  assign win_wdata = winner ? wdata1 : wdata0;
  assign win_we    = winner ? we1    : we0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic mis_q;  // current access was rejected as misaligned
  assign win_mis = (win_addr[1:0] != 2'b00);
`else
  assign win_mis = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first guarantees every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = win_mis ? DONE : ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant latching, hold counter, read-data capture.
  // NOTE: every register here is reset; the datapath is small, and a fully
  // defined post-reset state keeps rdata* and mem_* at 0 as observed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;  // port 0 wins the first tie
      gid        <= 1'b0;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_we     <= win_we;
            lat_addr   <= win_addr;
            lat_wdata  <= win_wdata;
            gid        <= winner;
            last_grant <= winner;
            cnt        <= CNT_INIT;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            mis_q      <= win_mis;
            // A rejected access returns zero data in its ack cycle.
            if (win_mis) begin
              if (winner) rdata1 <= '0;
              else        rdata0 <= '0;
            end
`endif
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            if (gid) rdata1 <= mem_out;
            else     rdata0 <= mem_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded only from state and latched fields, never from the
  // request inputs, so the memory interface has no combinational path from
  // req*/addr*.
  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memRead   = 1'b0;
    mem_memWrite  = 1'b0;
    if (state == ACCESS) begin
      mem_address   = lat_addr;
      mem_writeData = lat_wdata;
      mem_memRead   = ~lat_we;
      // Write strobe only in the final hold cycle: exactly one commit edge.
      mem_memWrite  = lat_we & (cnt == 4'd0);
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) & ~gid;
  assign ack1 = (state == DONE) &  gid;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign err = (state == DONE) & mis_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A behavioural model tracks the one
//   access in flight as a (port, op, start cycle, end cycle) record and a
//   reference memory; every cycle the DUT outputs are compared with what that
//   record implies. Stimulus is drawn from per-port op queues, some random.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_out;
  logic        mem_memRead, mem_memWrite, busy, err;

  always #5 clk = ~clk;

  dmem_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_out(mem_out), .busy(busy), .err(err)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:1023];
  assign mem_out = mem[mem_address[11:2]];
  always @(posedge clk) if (mem_memWrite) mem[mem_address[11:2]] <= mem_writeData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic [31:0] ref_mem [0:1023];
  op_t         q0[$], q1[$];
  bit          cur_act;
  int          cur_port;
  op_t         cur_op;
  int          cur_start, cur_end;
  bit          cur_mis;
  int          free_at;
  bit          m_last;
  logic [31:0] exp_rdata [2];
  int          gap [2];
  int          max_gap;
  bit          scramble;
  int          wr_cycles;
  int          log_port[$], log_cyc[$], log_err[$], grant_cyc[$];

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic op_t front_op(input int p);
    return (p == 0) ? q0[0] : q1[0];
  endfunction

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drive_port(input int p);
    bit  pending;
    op_t o;
    pending = cur_act && (cur_port == p);
    if (pending && scramble)
      set_port(p, 1'b0, 1'($urandom), $urandom, $urandom);
    else if (pending || (gap[p] == 0 && qsize(p) > 0)) begin
      o = front_op(p);
      set_port(p, 1'b1, o.we, o.addr, o.wdata);
    end else
      set_port(p, 1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic model_clear();
    cur_act = 0; free_at = 0; m_last = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    q0.delete(); q1.delete();
    gap[0] = 0; gap[1] = 0; max_gap = 0; scramble = 0; wr_cycles = 0;
    log_port.delete(); log_cyc.delete(); log_err.delete(); grant_cyc.delete();
  endtask

  // One cycle of comparison, completion bookkeeping, driving and arbitration.
  // Called at the falling edge, i.e. mid-cycle.
  task automatic step();
    int c, idx, w;
    bit in_acc, in_done;
    bit e_ack0, e_ack1, e_busy, e_rd, e_wr, e_err;
    c       = cyc;
    in_acc  = cur_act && !cur_mis && (c >= cur_start) && (c < cur_end);
    in_done = cur_act && (c == cur_end);
    e_busy  = in_acc || in_done;
    e_rd    = in_acc && !cur_op.we;
    e_wr    = in_acc && cur_op.we && (c == cur_end - 1);
    e_ack0  = in_done && (cur_port == 0);
    e_ack1  = in_done && (cur_port == 1);
    e_err   = in_done && cur_mis;
    if (in_done) begin
      idx = int'(cur_op.addr[11:2]);
      if (cur_mis)        exp_rdata[cur_port] = '0;
      else if (cur_op.we) ref_mem[idx] = cur_op.wdata;
      else                exp_rdata[cur_port] = ref_mem[idx];
    end

    checks++; if (ack0 !== e_ack0) begin errors++; $display("FAIL ack0 cyc=%0d got=%b exp=%b", c, ack0, e_ack0); end
    checks++; if (ack1 !== e_ack1) begin errors++; $display("FAIL ack1 cyc=%0d got=%b exp=%b", c, ack1, e_ack1); end
    checks++; if (busy !== e_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
    checks++; if (mem_memRead !== e_rd) begin errors++; $display("FAIL memRead cyc=%0d got=%b exp=%b", c, mem_memRead, e_rd); end
    checks++; if (mem_memWrite !== e_wr) begin errors++; $display("FAIL memWrite cyc=%0d got=%b exp=%b", c, mem_memWrite, e_wr); end
    checks++; if (err !== e_err) begin errors++; $display("FAIL err cyc=%0d got=%b exp=%b", c, err, e_err); end
    checks++; if (rdata0 !== exp_rdata[0]) begin errors++; $display("FAIL rdata0 cyc=%0d got=%h exp=%h", c, rdata0, exp_rdata[0]); end
    checks++; if (rdata1 !== exp_rdata[1]) begin errors++; $display("FAIL rdata1 cyc=%0d got=%h exp=%h", c, rdata1, exp_rdata[1]); end
    if (in_acc) begin
      checks++; if (mem_address !== cur_op.addr) begin errors++; $display("FAIL mem_address cyc=%0d got=%h exp=%h", c, mem_address, cur_op.addr); end
      checks++; if (mem_writeData !== cur_op.wdata) begin errors++; $display("FAIL mem_writeData cyc=%0d got=%h exp=%h", c, mem_writeData, cur_op.wdata); end
    end

    if (ack0 === 1'b1) begin log_port.push_back(0); log_cyc.push_back(c); log_err.push_back(int'(err)); end
    if (ack1 === 1'b1) begin log_port.push_back(1); log_cyc.push_back(c); log_err.push_back(int'(err)); end
    if (mem_memWrite === 1'b1) wr_cycles++;

    if (in_done) begin
      if (cur_port == 0) void'(q0.pop_front());
      else               void'(q1.pop_front());
      gap[cur_port] = $urandom_range(max_gap, 0);
      cur_act = 0;
    end
    for (int p = 0; p < 2; p++) if (gap[p] > 0) gap[p]--;
    drive_port(0);
    drive_port(1);

    // Arbitrate for the coming rising edge from the request levels just driven.
    if (!cur_act && (c + 1) >= free_at && (req0 || req1)) begin
      w         = (req0 && req1) ? int'(!m_last) : (req1 ? 1 : 0);
      cur_op    = front_op(w);
      cur_port  = w;
      cur_act   = 1;
      cur_start = c + 1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      cur_mis   = (cur_op.addr[1:0] != 2'b00);
`else
      cur_mis   = 0;
`endif
      cur_end   = cur_mis ? cur_start : cur_start + AC;
      free_at   = cur_end + 2;
      m_last    = w[0];
      grant_cyc.push_back(cur_start);
    end
  endtask

  task automatic run_ops(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cur_act) && n < budget) begin
      @(negedge clk); step(); n++;
    end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL run_budget got=%0d cycles required<%0d", n, budget); end
    repeat (3) begin @(negedge clk); step(); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic op_t mk(input bit w, input logic [31:0] a, input logic [31:0] d);
    op_t o; o.we = w; o.addr = a; o.wdata = d; return o;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    checks++; if ({ack0, ack1, busy, err, mem_memRead, mem_memWrite} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000000", {ack0, ack1, busy, err, mem_memRead, mem_memWrite}); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    checks++; if (mem_writeData !== 32'h0) begin errors++; $display("FAIL reset_mem_writeData got=%h exp=0", mem_writeData); end
  endtask

  task automatic test_single_read();
    apply_reset();
    mem[4] <= 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    q0.push_back(mk(0, 32'h10, $urandom));
    run_ops(100);
    checks++; if (log_port.size() != 1 || log_port[0] != 0) begin
      errors++; $display("FAIL single_read_acks got=%0d acks exp=1 on port 0", log_port.size()); end
    else begin
      checks++; if (log_cyc[0] - grant_cyc[0] != AC) begin
        errors++; $display("FAIL single_read_latency got=%0d exp=%0d", log_cyc[0] - grant_cyc[0], AC); end
    end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_read_data got=%h exp=deadbeef", rdata0); end
  endtask

  task automatic test_write_read();
    apply_reset();
    q1.push_back(mk(1, 32'h20, 32'h12345678));
    q1.push_back(mk(0, 32'h20, $urandom));
    run_ops(100);
    checks++; if (wr_cycles != 1) begin errors++; $display("FAIL write_strobe_cycles got=%0d exp=1", wr_cycles); end
    checks++; if (rdata1 !== 32'h12345678) begin errors++; $display("FAIL write_read_data got=%h exp=12345678", rdata1); end
    checks++; if (log_port.size() != 2 || log_port[0] != 1 || log_port[1] != 1) begin
      errors++; $display("FAIL write_read_acks got=%0d acks exp=2 on port 1", log_port.size()); end
  endtask

  task automatic test_fairness();
    int exp_order [4] = '{0, 1, 0, 1};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(0, {22'd0, 8'($urandom), 2'b00}, $urandom));
      q1.push_back(mk(0, {22'd0, 8'($urandom), 2'b00}, $urandom));
    end
    run_ops(200);
    checks++;
    if (log_port.size() != 4) begin errors++; $display("FAIL fair_count got=%0d exp=4", log_port.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (log_port[i] != exp_order[i]) begin
          errors++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", i, log_port[i], exp_order[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (log_cyc[i] - log_cyc[i-1] != AC + 2) begin
          errors++; $display("FAIL fair_spacing[%0d] got=%0d exp=%0d", i, log_cyc[i] - log_cyc[i-1], AC + 2); end
      end
    end
  endtask

  task automatic test_latched_fields();
    apply_reset();
    scramble = 1;
    mem[4] <= 32'hCAFEF00D; ref_mem[4] = 32'hCAFEF00D;
    q0.push_back(mk(0, 32'h10, 32'h0));
    q1.push_back(mk(1, 32'h44, 32'h0BADF00D));
    run_ops(100);
    checks++; if (log_port.size() != 2) begin errors++; $display("FAIL latched_acks got=%0d exp=2", log_port.size()); end
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL latched_read got=%h exp=cafef00d", rdata0); end
  endtask

  task automatic test_random();
    op_t o;
    apply_reset();
    max_gap = 3;
    for (int i = 0; i < 30; i++) begin
      o = mk(1'($urandom), {22'd0, 8'($urandom), 2'($urandom)}, $urandom); q0.push_back(o);
      o = mk(1'($urandom), {22'd0, 8'($urandom), 2'($urandom)}, $urandom); q1.push_back(o);
    end
    run_ops(2000);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin
        errors++; $display("FAIL random_mem[%0d] got=%h exp=%h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem[16] <= 32'hA5A5A5A5; ref_mem[16] = 32'hA5A5A5A5;
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 32'h40, 32'h11112222);
    @(negedge clk);  // first ACCESS cycle
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1; #1;
    checks++; if ({busy, ack0, mem_memWrite, mem_memRead} !== 4'b0) begin
      errors++; $display("FAIL mid_abort got=%b exp=0000", {busy, ack0, mem_memWrite, mem_memRead}); end
    set_port(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++; if ({ack0, ack1, mem_memWrite, busy} !== 4'b0) begin
        errors++; $display("FAIL mid_quiet got=%b exp=0000", {ack0, ack1, mem_memWrite, busy}); end
    end
    checks++; if (mem[16] !== 32'hA5A5A5A5) begin errors++; $display("FAIL mid_mem16 got=%h exp=a5a5a5a5", mem[16]); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    mem[4] <= 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    q0.push_back(mk(0, 32'h10, 32'h0));
    q0.push_back(mk(0, 32'h13, 32'h0));
    run_ops(100);
    checks++; if (log_port.size() != 2) begin errors++; $display("FAIL misaligned_acks got=%0d exp=2", log_port.size()); end
    else begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      checks++; if (log_cyc[1] != grant_cyc[1] || log_err[1] != 1) begin
        errors++; $display("FAIL misaligned_err got=lat%0d/err%0d exp=lat0/err1", log_cyc[1] - grant_cyc[1], log_err[1]); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL misaligned_rdata got=%h exp=0", rdata0); end
`else
      checks++; if (log_cyc[1] - grant_cyc[1] != AC || log_err[1] != 0) begin
        errors++; $display("FAIL misaligned_ignored got=lat%0d/err%0d exp=lat%0d/err0", log_cyc[1] - grant_cyc[1], log_err[1], AC); end
      checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_rdata got=%h exp=deadbeef", rdata0); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    model_clear();
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_fairness();
    test_latched_fields();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
